// File: rtl/if_fetch_ctrl_pkg.sv
// Shared constants, FSM state encoding and helpers for the instruction-fetch front end.
package if_fetch_ctrl_pkg;

    localparam logic [31:0] ZERO_WORD = 32'h0000_0000;
    localparam logic [31:0] NOP_INST  = 32'h0000_0013;
    localparam logic [31:0] PC_STEP   = 32'd4;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_ERR  = 2'd2
    } if_state_e;

    // The range check is widened to 33 bits so a PC close to 2^32 cannot wrap back into range.
    function automatic logic pc_fault(input logic [31:0] pc, input logic [32:0] last_ok);
        return (pc[1:0] != 2'b00) || ({1'b0, pc} > last_ok);
    endfunction

endpackage

// File: rtl/if_fetch_ctrl_if_id_reg.sv
// IF/ID pipeline register: flush loads a bubble, load captures a fetched word, otherwise holds.
module if_id_reg
    import if_fetch_ctrl_pkg::*;
#(
    parameter logic [31:0] NOP_INSTR = NOP_INST
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        flush_i,
    input  logic        load_i,
    input  logic [31:0] pc_i,
    input  logic [31:0] instr_i,
    output logic [31:0] pc_o,
    output logic [31:0] instr_o,
    output logic        valid_o
);

    logic [31:0] pc_q, pc_d;
    logic [31:0] instr_q, instr_d;
    logic        valid_q, valid_d;

    // Next-entry select: flush beats load; neither means hold (stall or idle).
    always_comb begin
        pc_d    = pc_q;
        instr_d = instr_q;
        valid_d = valid_q;
        if (flush_i) begin
            pc_d    = ZERO_WORD;
            instr_d = NOP_INSTR;
            valid_d = 1'b0;
        end else if (load_i) begin
            pc_d    = pc_i;
            instr_d = instr_i;
            valid_d = 1'b1;
        end
    end

    // Register the entry; reset leaves a bubble in place.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q    <= ZERO_WORD;
            instr_q <= NOP_INSTR;
            valid_q <= 1'b0;
        end else begin
            pc_q    <= pc_d;
            instr_q <= instr_d;
            valid_q <= valid_d;
        end
    end

    assign pc_o    = pc_q;
    assign instr_o = instr_q;
    assign valid_o = valid_q;

endmodule

// File: rtl/if_fetch_ctrl.sv
// Instruction-fetch front end: PC register, next-PC select, fault check, fetch FSM and
// accepted-instruction counter, feeding the IF/ID register.
//
//  state  | meaning
//  S_IDLE | one dead cycle after reset release, ROM disabled, nothing captured
//  S_RUN  | fetching; per cycle priority jump > fault > stall > advance
//  S_ERR  | fetch fault seen; ROM disabled, everything frozen until reset
module if_fetch_ctrl
    import if_fetch_ctrl_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int unsigned MEM_BYTES = 4096,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall_i,
    input  logic        jump_flag_i,
    input  logic [31:0] jump_addr_i,
    output logic        rom_ce_o,
    output logic [31:0] rom_pc_o,
    input  logic [31:0] rom_instr_i,
    output logic [31:0] id_pc_o,
    output logic [31:0] id_instr_o,
    output logic        id_valid_o,
    output logic        fetch_err_o,
    output logic [31:0] fetch_cnt_o
);

    localparam logic [32:0] LAST_PC = 33'(MEM_BYTES - 4);

    if_state_e   state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] cnt_q, cnt_d;
    logic        err_q, err_d;
    logic        ce_q, ce_d;
    logic        flush;
    logic        load;
    logic        fault;

    assign fault = pc_fault(pc_q, LAST_PC);

    // Next-state and next-PC decision for the fetch FSM.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        ce_d    = ce_q;
        flush   = 1'b0;
        load    = 1'b0;
        case (state_q)
            S_IDLE: begin
                state_d = S_RUN;
                ce_d    = 1'b1;
            end
            S_RUN: begin
                if (jump_flag_i) begin
                    // Wrong-path word in IF is dropped even if decode is stalled.
                    pc_d  = jump_addr_i;
                    flush = 1'b1;
                end else if (fault) begin
                    state_d = S_ERR;
                    err_d   = 1'b1;
                    ce_d    = 1'b0;
                    flush   = 1'b1;
                end else if (!stall_i) begin
                    load  = 1'b1;
                    pc_d  = pc_q + PC_STEP;
                    cnt_d = cnt_q + 32'd1;
                end
            end
            S_ERR: begin
                state_d = S_ERR;
            end
            default: begin
                state_d = S_IDLE;
                ce_d    = 1'b0;
            end
        endcase
    end

    // FSM state and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            pc_q    <= RESET_PC;
            cnt_q   <= 32'd0;
            err_q   <= 1'b0;
            ce_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            ce_q    <= ce_d;
        end
    end

    if_id_reg #(
        .NOP_INSTR(NOP_INSTR)
    ) u_if_id_reg (
        .clk    (clk),
        .rst_n  (rst_n),
        .flush_i(flush),
        .load_i (load),
        .pc_i   (pc_q),
        .instr_i(rom_instr_i),
        .pc_o   (id_pc_o),
        .instr_o(id_instr_o),
        .valid_o(id_valid_o)
    );

    assign rom_ce_o    = ce_q;
    assign rom_pc_o    = pc_q;
    assign fetch_err_o = err_q;
    assign fetch_cnt_o = cnt_q;

endmodule

// File: tb/tb_if_fetch_ctrl.sv
// Self-checking bench for if_fetch_ctrl: reference model plus a queue of expected IF/ID entries.
module tb_if_fetch_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        stall_i = 1'b0;
    logic        jump_flag_i = 1'b0;
    logic [31:0] jump_addr_i = 32'h0;
    logic        rom_ce_o;
    logic [31:0] rom_pc_o;
    logic [31:0] rom_instr_i;
    logic [31:0] id_pc_o;
    logic [31:0] id_instr_o;
    logic        id_valid_o;
    logic        fetch_err_o;
    logic [31:0] fetch_cnt_o;

    if_fetch_ctrl #(
        .RESET_PC (32'h0000_0000),
        .MEM_BYTES(4096),
        .NOP_INSTR(32'h0000_0013)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .stall_i    (stall_i),
        .jump_flag_i(jump_flag_i),
        .jump_addr_i(jump_addr_i),
        .rom_ce_o   (rom_ce_o),
        .rom_pc_o   (rom_pc_o),
        .rom_instr_i(rom_instr_i),
        .id_pc_o    (id_pc_o),
        .id_instr_o (id_instr_o),
        .id_valid_o (id_valid_o),
        .fetch_err_o(fetch_err_o),
        .fetch_cnt_o(fetch_cnt_o)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] rom_word(input logic [31:0] a);
        return {16'hC0DE, a[15:0]} ^ 32'h0000_5A5A;
    endfunction

    assign rom_instr_i = rom_word(rom_pc_o);

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
    } exp_t;

    exp_t        exp_q[$];
    exp_t        e;
    int          n_checks = 0;
    int          n_fail = 0;
    int          mstate;
    logic [31:0] mpc;
    logic [31:0] mcnt;
    logic [31:0] last_pc;
    logic [31:0] last_instr;

    function automatic bit m_fault(input logic [31:0] pc);
        return (pc[1:0] != 2'b00) || ({1'b0, pc} > 33'h0_0000_0FFC);
    endfunction

    task automatic model_reset();
        mstate = 0;
        mpc    = 32'h0;
        mcnt   = 32'h0;
        exp_q.delete();
    endtask

    // Drive one cycle of stimulus, advance the model, then step to 1 time unit after the edge.
    task automatic cycle(input logic s, input logic j, input logic [31:0] a);
        stall_i     = s;
        jump_flag_i = j;
        jump_addr_i = a;
        case (mstate)
            0: mstate = 1;
            1: begin
                if (j) mpc = a;
                else if (m_fault(mpc)) mstate = 2;
                else if (!s) begin
                    exp_q.push_back(exp_t'{pc: mpc, instr: rom_word(mpc)});
                    mpc  = mpc + 32'd4;
                    mcnt = mcnt + 32'd1;
                end
            end
            default: ;
        endcase
        @(posedge clk);
        #1;
        stall_i     = 1'b0;
        jump_flag_i = 1'b0;
    endtask

    // Reset pulse placed between edges.
    task automatic pulse_reset();
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
        model_reset();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if (rom_ce_o !== 1'b0) begin n_fail++; $display("FAIL reset_ce: got %b need 0", rom_ce_o); end
        n_checks++;
        if (rom_pc_o !== 32'h0) begin n_fail++; $display("FAIL reset_pc: got %h need 0", rom_pc_o); end
        n_checks++;
        if (id_valid_o !== 1'b0 || id_pc_o !== 32'h0 || id_instr_o !== 32'h13) begin
            n_fail++;
            $display("FAIL reset_ifid: got v=%b pc=%h ins=%h need 0/0/00000013", id_valid_o, id_pc_o, id_instr_o);
        end
        n_checks++;
        if (fetch_err_o !== 1'b0 || fetch_cnt_o !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_err_cnt: got err=%b cnt=%h need 0/0", fetch_err_o, fetch_cnt_o);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_fetch();
        cycle(1'b0, 1'b0, 32'h0);
        n_checks++;
        if (id_valid_o !== 1'b0 || fetch_cnt_o !== 32'h0 || rom_ce_o !== 1'b1) begin
            n_fail++;
            $display("FAIL idle_cycle: got v=%b cnt=%h ce=%b need 0/0/1", id_valid_o, fetch_cnt_o, rom_ce_o);
        end
        for (int i = 0; i < 4; i++) begin
            cycle(1'b0, 1'b0, 32'h0);
            n_checks++;
            if (id_valid_o !== 1'b1 || exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL fetch_capture: got valid=%b queued=%0d need valid=1", id_valid_o, exp_q.size());
            end else begin
                e = exp_q.pop_front();
                last_pc    = e.pc;
                last_instr = e.instr;
                if (id_pc_o !== e.pc || id_instr_o !== e.instr) begin
                    n_fail++;
                    $display("FAIL fetch_capture: got pc=%h ins=%h need pc=%h ins=%h", id_pc_o, id_instr_o, e.pc, e.instr);
                end
            end
        end
        n_checks++;
        if (fetch_cnt_o !== 32'd4 || rom_pc_o !== 32'h10) begin
            n_fail++;
            $display("FAIL fetch_cnt: got cnt=%h rom_pc=%h need 4/10", fetch_cnt_o, rom_pc_o);
        end
    endtask

    task automatic test_stall();
        for (int i = 0; i < 3; i++) begin
            cycle(1'b1, 1'b0, 32'h0);
            n_checks++;
            if (id_pc_o !== last_pc || id_instr_o !== last_instr || id_valid_o !== 1'b1) begin
                n_fail++;
                $display("FAIL stall_hold: got pc=%h ins=%h v=%b need pc=%h ins=%h v=1",
                         id_pc_o, id_instr_o, id_valid_o, last_pc, last_instr);
            end
            n_checks++;
            if (rom_pc_o !== mpc || fetch_cnt_o !== mcnt) begin
                n_fail++;
                $display("FAIL stall_pc_cnt: got pc=%h cnt=%h need pc=%h cnt=%h", rom_pc_o, fetch_cnt_o, mpc, mcnt);
            end
        end
        cycle(1'b0, 1'b0, 32'h0);
        n_checks++;
        if (id_valid_o !== 1'b1 || exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL stall_resume: got valid=%b queued=%0d need valid=1", id_valid_o, exp_q.size());
        end else begin
            e = exp_q.pop_front();
            if (id_pc_o !== e.pc || id_instr_o !== e.instr) begin
                n_fail++;
                $display("FAIL stall_resume: got pc=%h ins=%h need pc=%h ins=%h", id_pc_o, id_instr_o, e.pc, e.instr);
            end
        end
    endtask

    task automatic test_jump_over_stall();
        cycle(1'b1, 1'b1, 32'h40);
        n_checks++;
        if (id_valid_o !== 1'b0 || id_instr_o !== 32'h13 || id_pc_o !== 32'h0) begin
            n_fail++;
            $display("FAIL jump_bubble: got v=%b pc=%h ins=%h need 0/0/00000013", id_valid_o, id_pc_o, id_instr_o);
        end
        n_checks++;
        if (rom_pc_o !== 32'h40 || fetch_cnt_o !== mcnt) begin
            n_fail++;
            $display("FAIL jump_target: got pc=%h cnt=%h need pc=40 cnt=%h", rom_pc_o, fetch_cnt_o, mcnt);
        end
        for (int i = 0; i < 2; i++) begin
            cycle(1'b0, 1'b0, 32'h0);
            n_checks++;
            if (id_valid_o !== 1'b1 || exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL jump_capture: got valid=%b queued=%0d need valid=1", id_valid_o, exp_q.size());
            end else begin
                e = exp_q.pop_front();
                if (id_pc_o !== e.pc || id_instr_o !== e.instr) begin
                    n_fail++;
                    $display("FAIL jump_capture: got pc=%h ins=%h need pc=%h ins=%h", id_pc_o, id_instr_o, e.pc, e.instr);
                end
            end
        end
    endtask

    task automatic test_fault_misaligned();
        cycle(1'b0, 1'b1, 32'h42);
        n_checks++;
        if (fetch_err_o !== 1'b0 || rom_ce_o !== 1'b1 || rom_pc_o !== 32'h42 || id_valid_o !== 1'b0) begin
            n_fail++;
            $display("FAIL misalign_accept: got err=%b ce=%b pc=%h v=%b need 0/1/42/0",
                     fetch_err_o, rom_ce_o, rom_pc_o, id_valid_o);
        end
        cycle(1'b0, 1'b0, 32'h0);
        n_checks++;
        if (fetch_err_o !== 1'b1 || rom_ce_o !== 1'b0 || id_valid_o !== 1'b0) begin
            n_fail++;
            $display("FAIL misalign_fault: got err=%b ce=%b v=%b need 1/0/0", fetch_err_o, rom_ce_o, id_valid_o);
        end
        cycle(1'b0, 1'b1, 32'h80);
        cycle(1'b1, 1'b0, 32'h0);
        cycle(1'b0, 1'b0, 32'h0);
        n_checks++;
        if (fetch_err_o !== 1'b1 || rom_ce_o !== 1'b0 || id_valid_o !== 1'b0 || rom_pc_o !== 32'h42 || fetch_cnt_o !== mcnt) begin
            n_fail++;
            $display("FAIL err_sticky: got err=%b ce=%b v=%b pc=%h cnt=%h need 1/0/0/42/%h",
                     fetch_err_o, rom_ce_o, id_valid_o, rom_pc_o, fetch_cnt_o, mcnt);
        end
        pulse_reset();
        n_checks++;
        if (fetch_err_o !== 1'b0 || rom_pc_o !== 32'h0 || fetch_cnt_o !== 32'h0) begin
            n_fail++;
            $display("FAIL err_cleared: got err=%b pc=%h cnt=%h need 0/0/0", fetch_err_o, rom_pc_o, fetch_cnt_o);
        end
        cycle(1'b0, 1'b0, 32'h0);
        cycle(1'b0, 1'b0, 32'h0);
        n_checks++;
        if (id_valid_o !== 1'b1 || exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL restart_capture: got valid=%b queued=%0d need valid=1", id_valid_o, exp_q.size());
        end else begin
            e = exp_q.pop_front();
            if (id_pc_o !== e.pc || id_instr_o !== e.instr) begin
                n_fail++;
                $display("FAIL restart_capture: got pc=%h ins=%h need pc=%h ins=%h", id_pc_o, id_instr_o, e.pc, e.instr);
            end
        end
    endtask

    task automatic test_range_end();
        cycle(1'b0, 1'b1, 32'hFF8);
        for (int i = 0; i < 2; i++) begin
            cycle(1'b0, 1'b0, 32'h0);
            n_checks++;
            if (id_valid_o !== 1'b1 || exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL range_capture: got valid=%b queued=%0d need valid=1", id_valid_o, exp_q.size());
            end else begin
                e = exp_q.pop_front();
                if (id_pc_o !== e.pc || id_instr_o !== e.instr) begin
                    n_fail++;
                    $display("FAIL range_capture: got pc=%h ins=%h need pc=%h ins=%h", id_pc_o, id_instr_o, e.pc, e.instr);
                end
            end
        end
        n_checks++;
        if (id_pc_o !== 32'hFFC || rom_pc_o !== 32'h1000 || fetch_err_o !== 1'b0) begin
            n_fail++;
            $display("FAIL range_last: got id_pc=%h rom_pc=%h err=%b need FFC/1000/0", id_pc_o, rom_pc_o, fetch_err_o);
        end
        cycle(1'b0, 1'b0, 32'h0);
        n_checks++;
        if (fetch_err_o !== 1'b1 || id_valid_o !== 1'b0 || rom_ce_o !== 1'b0 || fetch_cnt_o !== mcnt) begin
            n_fail++;
            $display("FAIL range_fault: got err=%b v=%b ce=%b cnt=%h need 1/0/0/%h",
                     fetch_err_o, id_valid_o, rom_ce_o, fetch_cnt_o, mcnt);
        end
        pulse_reset();
        cycle(1'b0, 1'b0, 32'h0);
        cycle(1'b0, 1'b1, 32'hFFFF_FFFC);
        cycle(1'b0, 1'b0, 32'h0);
        n_checks++;
        if (fetch_err_o !== 1'b1 || id_valid_o !== 1'b0 || rom_pc_o !== 32'hFFFF_FFFC) begin
            n_fail++;
            $display("FAIL high_pc_fault: got err=%b v=%b pc=%h need 1/0/FFFFFFFC", fetch_err_o, id_valid_o, rom_pc_o);
        end
    endtask

    task automatic test_async_reset();
        pulse_reset();
        repeat (3) cycle(1'b0, 1'b0, 32'h0);
        n_checks++;
        if (fetch_cnt_o !== 32'd2 || id_valid_o !== 1'b1) begin
            n_fail++;
            $display("FAIL pre_async_run: got cnt=%h v=%b need 2/1", fetch_cnt_o, id_valid_o);
        end
        #3;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (rom_ce_o !== 1'b0 || rom_pc_o !== 32'h0 || id_valid_o !== 1'b0 || id_pc_o !== 32'h0 ||
            id_instr_o !== 32'h13 || fetch_cnt_o !== 32'h0 || fetch_err_o !== 1'b0) begin
            n_fail++;
            $display("FAIL async_reset: got ce=%b pc=%h v=%b idpc=%h ins=%h cnt=%h err=%b need 0/0/0/0/13/0/0",
                     rom_ce_o, rom_pc_o, id_valid_o, id_pc_o, id_instr_o, fetch_cnt_o, fetch_err_o);
        end
        rst_n = 1'b1;
        model_reset();
    endtask

    initial begin
        test_reset();
        test_fetch();
        test_stall();
        test_jump_over_stall();
        test_fault_misaligned();
        test_range_end();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
